// File: rtl/ed_window_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ed_window_ctrl : builds raster-order 3x3 windows for the ED edge detector
//                  and registers each returned edge flag with its centre.
// Revision 1.0
// ============================================================================
module ed_window_ctrl #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int XW    = 9,
  parameter int YW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [7:0]    win_a,
  output logic [7:0]    win_b,
  output logic [7:0]    win_c,
  output logic [7:0]    win_d,
  output logic [7:0]    win_e,
  output logic [7:0]    win_f,
  output logic [7:0]    win_g,
  output logic [7:0]    win_h,
  output logic [7:0]    win_i,
  output logic          ed_en_n,
  input  logic          ed_edge,
  output logic          edge_out,
  output logic          edge_valid,
  output logic [XW-1:0] edge_x,
  output logic [YW-1:0] edge_y,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  state_t        state_q;
  logic [XW-1:0] x_q, cx_q, ex_q;
  logic [YW-1:0] y_q, cy_q, ey_q;
  logic          drain_q, ready_q, busy_q, done_q;
  logic [7:0]    top1_q, top2_q, mid1_q, mid2_q, bot1_q, bot2_q;
  logic [7:0]    wa_q, wb_q, wc_q, wd_q, we_q, wf_q, wg_q, wh_q, wi_q;
  logic          en_n_q, edge_q, ev_q;

  // lb0 holds line y-1, lb1 holds line y-2; both rewritten in place at x.
  logic [7:0]    lb0_q [IMG_W];
  logic [7:0]    lb1_q [IMG_W];

  logic          xfer_w, fire_w;
  logic [7:0]    top_w, mid_w;

  assign xfer_w = pix_valid & ready_q;
  assign fire_w = xfer_w && (x_q >= X_TWO) && (y_q >= Y_TWO);
  assign top_w  = lb1_q[x_q];
  assign mid_w  = lb0_q[x_q];

  always_ff @(posedge clk) begin
    if (xfer_w) begin
      lb1_q[x_q] <= lb0_q[x_q];
      lb0_q[x_q] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      top1_q  <= '0; top2_q <= '0;
      mid1_q  <= '0; mid2_q <= '0;
      bot1_q  <= '0; bot2_q <= '0;
      wa_q    <= '0; wb_q <= '0; wc_q <= '0;
      wd_q    <= '0; we_q <= '0; wf_q <= '0;
      wg_q    <= '0; wh_q <= '0; wi_q <= '0;
      en_n_q  <= 1'b1;
      cx_q    <= '0;
      cy_q    <= '0;
      edge_q  <= 1'b0;
      ev_q    <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_STREAM;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        S_STREAM: begin
          if (xfer_w) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                y_q     <= '0;
                state_q <= S_DRAIN;
                ready_q <= 1'b0;
                drain_q <= 1'b0;
              end else begin
                y_q <= y_q + Y_ONE;
              end
            end else begin
              x_q <= x_q + X_ONE;
            end
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (xfer_w) begin
        top2_q <= top1_q; top1_q <= top_w;
        mid2_q <= mid1_q; mid1_q <= mid_w;
        bot2_q <= bot1_q; bot1_q <= pix_in;
      end

      // Window stage: ED evaluates during the single cycle en_n is low.
      en_n_q <= !fire_w;
      if (fire_w) begin
        wa_q <= top2_q; wb_q <= top1_q; wc_q <= top_w;
        wd_q <= mid2_q; we_q <= mid1_q; wf_q <= mid_w;
        wg_q <= bot2_q; wh_q <= bot1_q; wi_q <= pix_in;
        cx_q <= x_q - X_ONE;
        cy_q <= y_q - Y_ONE;
      end

      ev_q <= !en_n_q;
      if (!en_n_q) begin
        edge_q <= ed_edge;
        ex_q   <= cx_q;
        ey_q   <= cy_q;
      end
    end
  end

  assign pix_ready  = ready_q;
  assign win_a      = wa_q;
  assign win_b      = wb_q;
  assign win_c      = wc_q;
  assign win_d      = wd_q;
  assign win_e      = we_q;
  assign win_f      = wf_q;
  assign win_g      = wg_q;
  assign win_h      = wh_q;
  assign win_i      = wi_q;
  assign ed_en_n    = en_n_q;
  assign edge_out   = edge_q;
  assign edge_valid = ev_q;
  assign edge_x     = ex_q;
  assign edge_y     = ey_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ed_window_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ed_window_ctrl : directed frames against a scoreboard of windows/flags.
// Revision 1.0
// ============================================================================
module tb_ed_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int XW = 3;
  localparam int YW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [7:0]    win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_i;
  logic          ed_en_n, ed_edge, edge_out, edge_valid, busy, done;
  logic [XW-1:0] edge_x;
  logic [YW-1:0] edge_y;

  always #5 clk = ~clk;

  ed_window_ctrl #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .win_a(win_a), .win_b(win_b), .win_c(win_c), .win_d(win_d), .win_e(win_e),
    .win_f(win_f), .win_g(win_g), .win_h(win_h), .win_i(win_i),
    .ed_en_n(ed_en_n), .ed_edge(ed_edge), .edge_out(edge_out), .edge_valid(edge_valid),
    .edge_x(edge_x), .edge_y(edge_y), .busy(busy), .done(done)
  );

  function automatic int ad(input logic [7:0] p, input logic [7:0] q);
    return (p > q) ? int'(p) - int'(q) : int'(q) - int'(p);
  endfunction

  // ED model: edge when any opposite pair through the centre differs by more than 50.
  function automatic logic ed_fn(input logic [71:0] w);
    logic [7:0] a, b, c, d, f, g, h, i;
    a = w[71:64]; b = w[63:56]; c = w[55:48]; d = w[47:40];
    f = w[31:24]; g = w[23:16]; h = w[15:8];  i = w[7:0];
    return (ad(a, i) > 50) || (ad(c, g) > 50) || (ad(b, h) > 50) || (ad(d, f) > 50);
  endfunction

  assign ed_edge = ed_fn({win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_i});

  logic [7:0] img [H][W];

  function automatic logic [71:0] win_at(input int x, input int y);
    return {img[y-2][x-2], img[y-2][x-1], img[y-2][x],
            img[y-1][x-2], img[y-1][x-1], img[y-1][x],
            img[y][x-2],   img[y][x-1],   img[y][x]};
  endfunction

  function automatic int exp_ones_fn();
    int n = 0;
    for (int y = 2; y < H; y++)
      for (int x = 2; x < W; x++)
        if (ed_fn(win_at(x, y))) n++;
    return n;
  endfunction

  task automatic load_img(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0:       img[y][x] = 8'd120;
          1:       img[y][x] = (x < 4) ? 8'd0 : 8'd100;
          default: img[y][x] = 8'd0;
        endcase
    if (mode == 2) img[2][2] = 8'd50;
    if (mode == 3) img[2][2] = 8'd51;
  endtask

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard
  logic [71:0] win_q [$];
  logic [6:0]  flag_q [$];
  int  cur_x = 0, cur_y = 0;
  bit  mon_on = 1'b0;
  bit  exp_en_low = 1'b0;
  bit  exp_ev = 1'b0;
  int  frame_flags = 0, frame_ones = 0, done_cnt = 0;

  always @(posedge clk) begin
    exp_en_low = 1'b0;
    if (!rst && pix_valid && pix_ready && cur_x >= 2 && cur_y >= 2) begin
      win_q.push_back(win_at(cur_x, cur_y));
      flag_q.push_back({ed_fn(win_at(cur_x, cur_y)), XW'(cur_x - 1), YW'(cur_y - 1)});
      exp_en_low = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (ed_en_n !== 1'b1 || exp_en_low) check("ed_en_n", ed_en_n, !exp_en_low);
      if (edge_valid !== 1'b0 || exp_ev) check("edge_valid", edge_valid, exp_ev);
      exp_ev = exp_en_low && !rst;
      if (ed_en_n === 1'b0) begin
        check("win_avail", win_q.size() > 0, 1'b1);
        if (win_q.size() > 0)
          check("window", {win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_i},
                win_q.pop_front());
      end
      if (edge_valid === 1'b1) begin
        frame_flags++;
        if (edge_out) frame_ones++;
        check("flag_avail", flag_q.size() > 0, 1'b1);
        if (flag_q.size() > 0)
          check("flag", {edge_out, edge_x, edge_y}, flag_q.pop_front());
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, pix_ready, 1'b0);
    check({tag, "_en_n"}, ed_en_n, 1'b1);
    check({tag, "_win"}, {win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_i}, 72'd0);
    check({tag, "_edge"}, {edge_out, edge_valid, edge_x, edge_y}, 8'd0);
    check({tag, "_busy_done"}, {busy, done}, 2'b00);
  endtask

  task automatic begin_frame();
    frame_flags = 0; frame_ones = 0; done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start", busy, 1'b1);
    check("ready_start", pix_ready, 1'b1);
  endtask

  task automatic send_pixels(input bit gaps, input int limit, input int start_at);
    int n = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int t = 0;
        if (gaps)
          while ($urandom_range(0, 99) < 40) begin
            pix_valid = 1'b0; @(posedge clk); #1;
          end
        cur_x = x; cur_y = y;
        pix_in = img[y][x];
        pix_valid = 1'b1;
        start = (n == start_at);
        while (pix_ready !== 1'b1 && t < 50) begin
          @(posedge clk); #1; t++;
        end
        if (t == 50) begin
          check("ready_timeout", pix_ready, 1'b1);
          pix_valid = 1'b0; start = 1'b0;
          return;
        end
        @(posedge clk); #1;
        start = 1'b0;
        n++;
        if (n == limit) begin
          pix_valid = 1'b0;
          return;
        end
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic finish_frame(input int exp_ones);
    check("busy_drain", busy, 1'b1);
    check("ready_drain", pix_ready, 1'b0);
    check("done_early0", done, 1'b0);
    @(posedge clk); #1;
    check("done_early1", done, 1'b0);
    @(posedge clk); #1;
    check("done_pulse", {busy, done}, 2'b01);
    @(posedge clk); #1;
    check("done_clear", {busy, done}, 2'b00);
    check("flag_count", frame_flags, 32'((W - 2) * (H - 2)));
    check("ones_count", frame_ones, exp_ones);
    check("done_count", done_cnt, 1);
    check("flag_q_empty", flag_q.size(), 0);
    check("win_q_empty", win_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", passed, total);
    $fatal(1);
  end

  initial begin
    int saved;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Flat frame, continuous valid
    load_img(0);
    begin_frame();
    send_pixels(1'b0, -1, -1);
    finish_frame(0);

    // Vertical step, continuous valid
    load_img(1);
    begin_frame();
    send_pixels(1'b0, -1, -1);
    finish_frame(8);

    // Threshold around 50
    load_img(2);
    begin_frame();
    send_pixels(1'b0, -1, -1);
    finish_frame(exp_ones_fn());
    load_img(3);
    begin_frame();
    send_pixels(1'b0, -1, -1);
    finish_frame(exp_ones_fn());

    // Step image with random valid gaps
    load_img(1);
    begin_frame();
    send_pixels(1'b1, -1, -1);
    finish_frame(8);

    // Reset at the 20th transfer, then a clean frame
    begin_frame();
    send_pixels(1'b0, 20, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    win_q.delete();
    flag_q.delete();
    saved = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, saved);
    check("midrst_idle", {busy, pix_ready}, 2'b00);
    begin_frame();
    send_pixels(1'b0, -1, -1);
    finish_frame(8);

    // start pulsed during STREAM is ignored
    load_img(0);
    begin_frame();
    send_pixels(1'b0, -1, 10);
    finish_frame(0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ed_window_ctrl.md
Name: ed_window_ctrl

Overview:
- Streams an 8-bit grayscale frame in raster order and builds a 3x3 neighbourhood window using two line buffers and column shift registers.
- Presents each interior window to the ED edge detector, drives its active-low enable, and registers the returned edge flag with its centre coordinates.
- Sits between the pixel source and the haze-removal refinement stage, which consumes the edge map.

Parameters:
- IMG_W, 320, pixels per line (>=3)
- IMG_H, 240, lines per frame (>=3)
- XW, 9, width of x counters/coordinates (2^XW >= IMG_W)
- YW, 8, width of y counters/coordinates (2^YW >= IMG_H)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when IDLE
- pix_in  in  8  input pixel
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  controller accepts pixel; transfer = pix_valid & pix_ready
- win_a..win_i  out  8 each  window to ED (a,b,c = top row L..R; d,e,f = middle row; g,h,i = bottom row)
- ed_en_n  out  1  ED enable, active low (0 = evaluate)
- ed_edge  in  1  ED result (combinational from win_*)
- edge_out  out  1  registered edge flag
- edge_valid  out  1  edge_out/edge_x/edge_y valid, one-cycle strobe per flag
- edge_x  out  XW  centre column of flagged window
- edge_y  out  YW  centre row of flagged window
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state IDLE, all counters 0, pix_ready=0, ed_en_n=1, win_*=0, edge_out=0, edge_valid=0, edge_x=0, edge_y=0, busy=0, done=0. Line-buffer contents need not be cleared.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE: on start, go to STREAM, set busy=1, x=y=0.
  - STREAM: pix_ready=1. On each transfer, x increments. At x=IMG_W-1, x wraps to 0 and y increments. After transferring (IMG_W-1, IMG_H-1), go to DRAIN with pix_ready=0 from the next cycle.
  - DRAIN: lasts exactly 2 cycles, letting the final window and flag retire, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start is ignored outside IDLE.
- pix_valid gaps: counters, buffers and shift registers hold. No window or flag is generated on a non-transfer cycle.
- Window on transfer of pixel (x,y) with x>=2 and y>=2:
  - Row contents: top row from line y-2, middle row from line y-1, bottom row from line y; columns x-2, x-1, x.
  - Line buffer 0 holds line y-1 and line buffer 1 holds line y-2, each IMG_W deep, updated in place at address x.
  - Windows never span a line wrap; x<2 or y<2 produce no window.
- Timing:
  - Cycle N: transfer.
  - Cycle N+1: win_* registered and ed_en_n=0 for exactly this one cycle.
  - Cycle N+2: edge_out = ed_edge sampled at end of N+1, edge_valid=1, edge_x = x-1, edge_y = y-1.
  - ed_en_n=1 on all other cycles. win_* hold their last value, since ED retains state when disabled.
- Flag count per frame: exactly (IMG_W-2)*(IMG_H-2), in raster order of centre.
- Back-to-back transfers give one flag per cycle (full throughput).
- Reset mid-frame: immediate return to reset values, with no done pulse. The next start begins a fresh frame.
- Border pixels (outer ring) never receive a flag. The downstream stage treats them as non-edge.

Test Plan (IMG_W=8, IMG_H=6 unless noted):
- Flat frame, all pixels 120, continuous valid -> 24 flags, all edge_out=0; coordinates run (1,1)..(6,4) in raster order; done pulses once, 2 cycles after the last flag's transfer cycle + DRAIN; busy is low afterwards.
- Vertical step (x<4 -> 0, x>=4 -> 100) -> edge_out=1 exactly at edge_x=3 and 4 on every row 1..4 (8 flags); all others 0.
- Threshold: single window with a=0, i=50, all else 0 -> edge_out=0; repeat with i=51 -> edge_out=1.
- Random pix_valid gaps (about 40% idle) on the step image -> identical flag sequence to the continuous case; ed_en_n low only in cycles following a transfer with x>=2 and y>=2.
- Assert rst at the 20th transfer -> all outputs return to reset values the next cycle with no done; a new start and full frame yields exactly 24 correct flags.
- start pulsed during STREAM -> no effect on counters, flag count or done timing.
